// File: rtl/usb_buffer_arbiter_if.sv
// CPU, USB and buffer-RAM ports of the packet buffer arbiter.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface usb_buffer_arbiter_if #(
  parameter int ADDRESS_WIDTH = 8
);
  logic                     cpu_req;
  logic [ADDRESS_WIDTH-1:0] cpu_address;
  logic [3:0]               cpu_write_sections;
  logic [31:0]              cpu_write_value;
  logic                     cpu_ready;
  logic                     cpu_read_valid;
  logic [31:0]              cpu_read_value;

  logic                     usb_req;
  logic [ADDRESS_WIDTH-1:0] usb_address;
  logic                     usb_write;
  logic [31:0]              usb_write_value;
  logic                     usb_ready;
  logic                     usb_read_valid;
  logic [31:0]              usb_read_value;

  logic [ADDRESS_WIDTH-1:0] mem_address;
  logic [3:0]               mem_write_sections;
  logic [31:0]              mem_write_value;
  logic [31:0]              mem_read_value;

  modport slave (
    input  cpu_req, cpu_address, cpu_write_sections, cpu_write_value,
    output cpu_ready, cpu_read_valid, cpu_read_value,
    input  usb_req, usb_address, usb_write, usb_write_value,
    output usb_ready, usb_read_valid, usb_read_value,
    output mem_address, mem_write_sections, mem_write_value,
    input  mem_read_value
  );

  modport master (
    output cpu_req, cpu_address, cpu_write_sections, cpu_write_value,
    input  cpu_ready, cpu_read_valid, cpu_read_value,
    output usb_req, usb_address, usb_write, usb_write_value,
    input  usb_ready, usb_read_valid, usb_read_value,
    input  mem_address, mem_write_sections, mem_write_value,
    output mem_read_value
  );
endinterface

// File: rtl/usb_buffer_arbiter.sv
// Arbitrates CPU and USB access to a shared single-port packet buffer and tracks
// which side owns the buffer; writes by the non-owner are dropped and flagged.
module usb_buffer_arbiter #(
  parameter int ADDRESS_WIDTH    = 8,
  parameter int STARVATION_LIMIT = 4
) (
  input  logic                   clk48,
  input  logic                   reset,
  usb_buffer_arbiter_if.slave    bus,
  input  logic                   got_usb_packet,
  input  logic                   handled_usb_packet,
  output logic                   usb_packet_ready,
  output logic                   packet_overrun,
  output logic                   cpu_write_violation,
  output logic                   usb_write_violation
);

  localparam logic [3:0] WAIT_LIMIT = 4'(STARVATION_LIMIT);

  typedef enum logic {USB_OWNS, CPU_OWNS} own_state_t;

  own_state_t state;
  own_state_t next_state;
  logic [3:0] cpu_wait_count;
  logic       cpu_grant;
  logic       usb_grant;
  logic       cpu_read_pending;
  logic       usb_read_pending;
  logic       cpu_is_write;

  assign cpu_is_write = |bus.cpu_write_sections;

  // Only the pulse meaningful in the current state is acted on.
  always_comb begin
    next_state = state;
    case (state)
      USB_OWNS: if (got_usb_packet)     next_state = CPU_OWNS;
      CPU_OWNS: if (handled_usb_packet) next_state = USB_OWNS;
      default:  next_state = USB_OWNS;
    endcase
  end

  // USB wins ties unless the CPU has been blocked long enough.
  always_comb begin
    usb_grant = 1'b0;
    cpu_grant = 1'b0;
    if (!reset) begin
      if (bus.usb_req && !(bus.cpu_req && cpu_wait_count == WAIT_LIMIT))
        usb_grant = 1'b1;
      else if (bus.cpu_req)
        cpu_grant = 1'b1;
    end
  end

  always_comb begin
    bus.mem_address        = '0;
    bus.mem_write_sections = 4'b0000;
    bus.mem_write_value    = 32'h0;
    if (usb_grant) begin
      bus.mem_address        = bus.usb_address;
      bus.mem_write_sections = (bus.usb_write && state == USB_OWNS) ? 4'b1111 : 4'b0000;
      bus.mem_write_value    = bus.usb_write_value;
    end else if (cpu_grant) begin
      bus.mem_address        = bus.cpu_address;
      bus.mem_write_sections = (state == CPU_OWNS) ? bus.cpu_write_sections : 4'b0000;
      bus.mem_write_value    = bus.cpu_write_value;
    end
  end

  // Reset masks a read that was granted just before it asserted.
  always_comb begin
    bus.cpu_ready      = cpu_grant;
    bus.usb_ready      = usb_grant;
    bus.cpu_read_valid = cpu_read_pending && !reset;
    bus.usb_read_valid = usb_read_pending && !reset;
    bus.cpu_read_value = bus.cpu_read_valid ? bus.mem_read_value : 32'h0;
    bus.usb_read_value = bus.usb_read_valid ? bus.mem_read_value : 32'h0;
  end

  always_ff @(posedge clk48) begin
    if (reset) begin
      state               <= USB_OWNS;
      usb_packet_ready    <= 1'b0;
      cpu_wait_count      <= 4'd0;
      cpu_read_pending    <= 1'b0;
      usb_read_pending    <= 1'b0;
      packet_overrun      <= 1'b0;
      cpu_write_violation <= 1'b0;
      usb_write_violation <= 1'b0;
    end else begin
      state            <= next_state;
      usb_packet_ready <= (next_state == CPU_OWNS);
      cpu_read_pending <= cpu_grant && !cpu_is_write;
      usb_read_pending <= usb_grant && !bus.usb_write;

      if (cpu_grant || !bus.cpu_req)
        cpu_wait_count <= 4'd0;
      else if (cpu_wait_count != WAIT_LIMIT)
        cpu_wait_count <= cpu_wait_count + 4'd1;

      if (state == CPU_OWNS && got_usb_packet && !handled_usb_packet)
        packet_overrun <= 1'b1;
      if (cpu_grant && cpu_is_write && state == USB_OWNS)
        cpu_write_violation <= 1'b1;
      if (usb_grant && bus.usb_write && state == CPU_OWNS)
        usb_write_violation <= 1'b1;
    end
  end

endmodule

// File: tb/tb_usb_buffer_arbiter.sv
// Directed bench for usb_buffer_arbiter with a behavioural synchronous-read RAM;
// address 5 comes out of reset holding 0xDEADBEEF, everything else zero.
module tb_usb_buffer_arbiter;

  logic clk48 = 1'b0;
  logic reset;
  logic got_usb_packet;
  logic handled_usb_packet;
  logic usb_packet_ready;
  logic packet_overrun;
  logic cpu_write_violation;
  logic usb_write_violation;
  logic [31:0] ram [256];
  int checks = 0;
  int errors = 0;
  logic prev_usb_grant;

  usb_buffer_arbiter_if #(.ADDRESS_WIDTH(8)) bus ();

  usb_buffer_arbiter #(.ADDRESS_WIDTH(8), .STARVATION_LIMIT(4)) dut (
    .clk48               (clk48),
    .reset               (reset),
    .bus                 (bus),
    .got_usb_packet      (got_usb_packet),
    .handled_usb_packet  (handled_usb_packet),
    .usb_packet_ready    (usb_packet_ready),
    .packet_overrun      (packet_overrun),
    .cpu_write_violation (cpu_write_violation),
    .usb_write_violation (usb_write_violation)
  );

  always #5 clk48 = ~clk48;

  always @(posedge clk48) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) ram[i] <= 32'h0;
      ram[5] <= 32'hDEADBEEF;
    end else begin
      for (int b = 0; b < 4; b++)
        if (bus.mem_write_sections[b])
          ram[bus.mem_address][8*b +: 8] <= bus.mem_write_value[8*b +: 8];
    end
    bus.mem_read_value <= ram[bus.mem_address];
  end

  task automatic tick();
    @(posedge clk48);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
  endtask

  task automatic cpu_access(input logic req, input logic [7:0] addr, input logic [3:0] sections, input logic [31:0] value);
    bus.cpu_req            = req;
    bus.cpu_address        = addr;
    bus.cpu_write_sections = sections;
    bus.cpu_write_value    = value;
  endtask

  task automatic usb_access(input logic req, input logic [7:0] addr, input logic wr, input logic [31:0] value);
    bus.usb_req         = req;
    bus.usb_address     = addr;
    bus.usb_write       = wr;
    bus.usb_write_value = value;
  endtask

  initial begin
    reset              = 1'b1;
    got_usb_packet     = 1'b0;
    handled_usb_packet = 1'b0;
    cpu_access(1'b1, 8'd0, 4'b0000, 32'h0);
    usb_access(1'b1, 8'd0, 1'b1, 32'hFFFF_FFFF);
    tick();
    tick();
    #1;
    check_output("rst_cpu_ready", bus.cpu_ready, 1'b0);
    check_output("rst_usb_ready", bus.usb_ready, 1'b0);
    check_output("rst_mem_sections", bus.mem_write_sections, 4'b0000);
    check_output("rst_cpu_read_valid", bus.cpu_read_valid, 1'b0);
    check_output("rst_usb_read_valid", bus.usb_read_valid, 1'b0);
    check_output("rst_packet_ready", usb_packet_ready, 1'b0);
    check_output("rst_flags", {packet_overrun, cpu_write_violation, usb_write_violation}, 3'b000);

    // CPU-only read of address 5
    reset = 1'b0;
    usb_access(1'b0, 8'd0, 1'b0, 32'h0);
    cpu_access(1'b1, 8'd5, 4'b0000, 32'h0);
    #1;
    check_output("cpu_rd_ready", bus.cpu_ready, 1'b1);
    check_output("cpu_rd_usb_ready", bus.usb_ready, 1'b0);
    check_output("cpu_rd_mem_address", bus.mem_address, 8'd5);
    check_output("cpu_rd_mem_sections", bus.mem_write_sections, 4'b0000);
    tick();
    cpu_access(1'b0, 8'd0, 4'b0000, 32'h0);
    #1;
    check_output("cpu_rd_valid", bus.cpu_read_valid, 1'b1);
    check_output("cpu_rd_value", bus.cpu_read_value, 32'hDEADBEEF);
    check_output("cpu_rd_idle_address", bus.mem_address, 8'd0);
    tick();
    check_output("cpu_rd_valid_drop", bus.cpu_read_valid, 1'b0);
    check_output("cpu_rd_value_zero", bus.cpu_read_value, 32'h0);

    // Both held: four USB grants then one CPU grant, repeating
    cpu_access(1'b1, 8'd1, 4'b0000, 32'h0);
    usb_access(1'b1, 8'd3, 1'b0, 32'h0);
    prev_usb_grant = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      check_output($sformatf("starve_usb_ready_%0d", i), bus.usb_ready, (i % 5) != 4);
      check_output($sformatf("starve_cpu_ready_%0d", i), bus.cpu_ready, (i % 5) == 4);
      if (i > 0)
        check_output($sformatf("starve_usb_rvalid_%0d", i), bus.usb_read_valid, prev_usb_grant);
      prev_usb_grant = ((i % 5) != 4);
      tick();
    end
    cpu_access(1'b0, 8'd0, 4'b0000, 32'h0);
    usb_access(1'b0, 8'd0, 1'b0, 32'h0);
    tick();

    // Writes while the USB side owns the buffer
    cpu_access(1'b1, 8'd7, 4'b1111, 32'hAAAA5555);
    #1;
    check_output("cpu_viol_ready", bus.cpu_ready, 1'b1);
    check_output("cpu_viol_sections", bus.mem_write_sections, 4'b0000);
    tick();
    cpu_access(1'b0, 8'd0, 4'b0000, 32'h0);
    usb_access(1'b1, 8'd9, 1'b1, 32'h12345678);
    #1;
    check_output("cpu_viol_flag", cpu_write_violation, 1'b1);
    check_output("cpu_wr_no_rvalid", bus.cpu_read_valid, 1'b0);
    check_output("usb_wr_ready", bus.usb_ready, 1'b1);
    check_output("usb_wr_sections", bus.mem_write_sections, 4'b1111);
    check_output("usb_wr_value", bus.mem_write_value, 32'h12345678);
    tick();
    usb_access(1'b0, 8'd0, 1'b0, 32'h0);
    #1;
    check_output("usb_wr_no_violation", usb_write_violation, 1'b0);

    // Hand the buffer to the CPU
    got_usb_packet = 1'b1;
    #1;
    check_output("got_ready_not_yet", usb_packet_ready, 1'b0);
    tick();
    got_usb_packet = 1'b0;
    cpu_access(1'b1, 8'd2, 4'b0011, 32'h11223344);
    #1;
    check_output("got_ready_set", usb_packet_ready, 1'b1);
    check_output("cpu_own_wr_ready", bus.cpu_ready, 1'b1);
    check_output("cpu_own_wr_address", bus.mem_address, 8'd2);
    check_output("cpu_own_wr_sections", bus.mem_write_sections, 4'b0011);
    check_output("cpu_own_wr_value", bus.mem_write_value, 32'h11223344);
    tick();
    cpu_access(1'b0, 8'd0, 4'b0000, 32'h0);
    usb_access(1'b1, 8'd4, 1'b1, 32'h55555555);
    #1;
    check_output("usb_viol_ready", bus.usb_ready, 1'b1);
    check_output("usb_viol_sections", bus.mem_write_sections, 4'b0000);
    tick();
    usb_access(1'b0, 8'd0, 1'b0, 32'h0);
    cpu_access(1'b1, 8'd2, 4'b0000, 32'h0);
    #1;
    check_output("usb_viol_flag", usb_write_violation, 1'b1);
    tick();
    cpu_access(1'b0, 8'd0, 4'b0000, 32'h0);
    #1;
    check_output("byte_wr_readback", bus.cpu_read_value, 32'h00003344);

    // Overrun, then both pulses together
    got_usb_packet = 1'b1;
    tick();
    got_usb_packet = 1'b0;
    #1;
    check_output("overrun_flag", packet_overrun, 1'b1);
    check_output("overrun_state_kept", usb_packet_ready, 1'b1);
    got_usb_packet     = 1'b1;
    handled_usb_packet = 1'b1;
    tick();
    got_usb_packet     = 1'b0;
    handled_usb_packet = 1'b0;
    #1;
    check_output("both_pulses_release", usb_packet_ready, 1'b0);

    // Write permission follows the state at the start of the cycle
    got_usb_packet = 1'b1;
    cpu_access(1'b1, 8'd8, 4'b1111, 32'h0BADF00D);
    #1;
    check_output("same_cycle_got_sections", bus.mem_write_sections, 4'b0000);
    tick();
    got_usb_packet     = 1'b0;
    handled_usb_packet = 1'b1;
    #1;
    check_output("same_cycle_handled_sections", bus.mem_write_sections, 4'b1111);
    tick();
    handled_usb_packet = 1'b1;
    cpu_access(1'b0, 8'd0, 4'b0000, 32'h0);
    #1;
    check_output("handled_released", usb_packet_ready, 1'b0);
    tick();
    handled_usb_packet = 1'b0;
    #1;
    check_output("handled_ignored_usb_owns", usb_packet_ready, 1'b0);
    check_output("flags_sticky", {packet_overrun, cpu_write_violation, usb_write_violation}, 3'b111);

    // Reset right after a CPU read grant
    cpu_access(1'b1, 8'd5, 4'b0000, 32'h0);
    tick();
    cpu_access(1'b0, 8'd0, 4'b0000, 32'h0);
    reset = 1'b1;
    usb_access(1'b1, 8'd5, 1'b0, 32'h0);
    #1;
    check_output("rst2_cpu_read_valid", bus.cpu_read_valid, 1'b0);
    check_output("rst2_cpu_read_value", bus.cpu_read_value, 32'h0);
    check_output("rst2_usb_ready", bus.usb_ready, 1'b0);
    tick();
    check_output("rst2_flags", {packet_overrun, cpu_write_violation, usb_write_violation}, 3'b000);
    check_output("rst2_packet_ready", usb_packet_ready, 1'b0);
    check_output("rst2_mem_sections", bus.mem_write_sections, 4'b0000);
    reset = 1'b0;
    #1;
    check_output("post_rst_usb_ready", bus.usb_ready, 1'b1);
    check_output("post_rst_mem_address", bus.mem_address, 8'd5);
    tick();
    usb_access(1'b0, 8'd0, 1'b0, 32'h0);
    #1;
    check_output("post_rst_usb_rvalid", bus.usb_read_valid, 1'b1);
    check_output("post_rst_usb_rvalue", bus.usb_read_value, 32'hDEADBEEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/usb_buffer_arbiter.md
USB_BUFFER_ARBITER -- requirements
Module: usb_buffer_arbiter

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 8, word-address width of the packet buffer (256 x 32-bit words).
REQ-002 SHALL have parameter STARVATION_LIMIT, default 4, the number of consecutive blocked CPU cycles after which the CPU wins arbitration; legal range is 1..15.
REQ-003 SHALL have one clock and a synchronous, active-high reset, with ports as follows.
- clk48  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU access request; CPU holds it and all cpu_* fields until cpu_ready.
- cpu_address  in  ADDRESS_WIDTH  CPU word address.
- cpu_write_sections  in  4  CPU byte enables; 0 means read.
- cpu_write_value  in  32  CPU write data, already byte-lane aligned.
- cpu_ready  out  1  CPU request granted this cycle.
- cpu_read_valid  out  1  CPU read data valid.
- cpu_read_value  out  32  CPU read data.
- usb_req  in  1  USB-side access request; same hold rule as cpu_req.
- usb_address  in  ADDRESS_WIDTH  USB word address.
- usb_write  in  1  USB full-word write; 0 means read.
- usb_write_value  in  32  USB write data.
- usb_ready, usb_read_valid, usb_read_value  out  1/1/32  USB-side equivalents of the cpu_* outputs.
- got_usb_packet  in  1  one-cycle pulse; the USB engine has finished filling the buffer.
- handled_usb_packet  in  1  one-cycle pulse; the CPU releases the buffer.
- usb_packet_ready  out  1  buffer is owned by the CPU.
- packet_overrun  out  1  sticky error flag.
- cpu_write_violation, usb_write_violation  out  1  sticky error flags.
- mem_address  out  ADDRESS_WIDTH  buffer RAM address.
- mem_write_sections  out  4  buffer RAM byte write enables.
- mem_write_value  out  32  buffer RAM write data.
- mem_read_value  in  32  buffer RAM read data; synchronous read, valid one cycle after the address is presented.

Function
REQ-004 SHALL grant at most one requester per cycle; the grant is combinational from the current-cycle req signals and state.
REQ-005 SHALL give USB priority: with both requests asserted, USB is granted unless cpu_wait_count == STARVATION_LIMIT, in which case the CPU is granted.
REQ-006 SHALL keep a 4-bit cpu_wait_count with this update rule:
- increments, saturating at STARVATION_LIMIT, on each cycle with cpu_req=1 and cpu_ready=0;
- clears to 0 on a CPU grant or when cpu_req=0.
REQ-007 SHALL grant a lone requester in the same cycle it requests, giving zero-wait access when uncontended.
REQ-008 SHALL drive the RAM port from the granted requester's fields in the grant cycle; USB writes use sections 4'b1111.
REQ-009 SHALL, when there is no grant, drive mem_address=0, mem_write_sections=0 and mem_write_value=0.
REQ-010 SHALL treat a granted read in cycle N as follows: the requester's read_valid=1 in cycle N+1, and read_value=mem_read_value in that cycle.
REQ-011 SHALL hold read_valid low in all other cycles and SHALL hold read_value at 0 whenever read_valid is 0.
REQ-012 SHALL implement an ownership FSM with states USB_OWNS (reset state) and CPU_OWNS.
REQ-013 SHALL transition USB_OWNS->CPU_OWNS on got_usb_packet and CPU_OWNS->USB_OWNS on handled_usb_packet.
REQ-014 SHALL apply only the pulse valid for the current state when both pulses arrive in the same cycle, and SHALL ignore the other pulse.
REQ-015 SHALL set packet_overrun on got_usb_packet while in CPU_OWNS, with no state change.
REQ-016 SHALL ignore handled_usb_packet while in USB_OWNS.
REQ-017 SHALL register usb_packet_ready as (next state == CPU_OWNS), so it rises one cycle after the got_usb_packet pulse.
REQ-018 SHALL, for a granted CPU write in USB_OWNS, still assert cpu_ready, force mem_write_sections=0 and set cpu_write_violation.
REQ-019 SHALL, for a granted USB write in CPU_OWNS, still assert usb_ready, force mem_write_sections=0 and set usb_write_violation.
REQ-020 SHALL allow reads by either side in either state.
REQ-021 SHALL clear the sticky flags only on reset.
REQ-022 SHALL evaluate ownership for the write check on the state at the start of the cycle, so a same-cycle got/handled pulse does not change that cycle's write permission.

Reset
REQ-023 SHALL, while reset=1, force:
- state=USB_OWNS and cpu_wait_count=0;
- usb_packet_ready=0 and all sticky flags=0;
- both read_valid=0 and both ready=0;
- mem_write_sections=0.
REQ-024 SHALL suppress the read_valid of a read granted in the cycle before reset asserts.
REQ-025 SHALL grant no request while reset=1 and SHALL resume arbitration in the first cycle after reset deasserts.

Verification
REQ-026 SHALL cover: CPU-only read of address 5 holding 0xDEADBEEF -> cpu_ready in cycle N, cpu_read_valid=1 with value 0xDEADBEEF in cycle N+1.
REQ-027 SHALL cover: usb_req and cpu_req held continuously, STARVATION_LIMIT=4 -> USB granted 4 cycles, CPU granted on the 5th, pattern repeats.
REQ-028 SHALL cover: got_usb_packet pulse -> usb_packet_ready=1 next cycle; CPU write 0x11223344 with sections 4'b0011 to address 2 -> RAM enables 4'b0011; handled_usb_packet -> usb_packet_ready=0.
REQ-029 SHALL cover: CPU write while in USB_OWNS -> cpu_ready=1, mem_write_sections=0, cpu_write_violation=1 until reset.
REQ-030 SHALL cover: got_usb_packet in CPU_OWNS -> packet_overrun=1 and state unchanged; got and handled in the same cycle in CPU_OWNS -> state returns to USB_OWNS.
REQ-031 SHALL cover: reset asserted the cycle after a CPU read grant -> no cpu_read_valid, all outputs at reset values, USB granted on its first post-reset request.
